// File: rtl/raise_frame_sink.sv
// Ping-pong frame sink: scatters raiseFreq bins into a bank, replays closed frames in bin order to the IFFT.
// Optional RAISE_SINK_STAT_EN adds saturating frame_cnt/drop_cnt ports.
module raise_frame_sink #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BIN_W  = 6,
  parameter int unsigned NBINS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raise_valid,
  input  logic [DATA_W-1:0] raise_data,
  input  logic [BIN_W-1:0]  freq_out,
  input  logic              raise_fin,
  output logic              ifft_valid,
  input  logic              ifft_ready,
  output logic [DATA_W-1:0] ifft_data,
  output logic [BIN_W-1:0]  ifft_idx,
  output logic              ifft_fin,
  output logic              drop
`ifdef RAISE_SINK_STAT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [BIN_W-1:0] LAST = BIN_W'(NBINS - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_fill;
  logic              r_pend;
  logic [BIN_W-1:0]  r_cnt;
  logic [NBINS-1:0]  r_occ [2];
  logic [DATA_W-1:0] r_bank [2][NBINS];

  logic              r_valid;
  logic              r_fin;
  logic              r_drop;
  logic [DATA_W-1:0] r_data;
  logic [BIN_W-1:0]  r_idx;

  logic              w_free;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_rd_bank;
  logic [BIN_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_word;

  // A frame can only close when no earlier frame is still pending or draining.
  assign w_free    = (r_state == S_IDLE) && !r_pend;
  assign w_hs      = r_valid && ifft_ready;
  assign w_last_hs = w_hs && (r_cnt == LAST);
  assign w_rd_bank = ~r_fill;
  assign w_rd_idx  = (r_state == S_DRAIN) ? r_cnt + 1'b1 : '0;
  assign w_word    = r_occ[w_rd_bank][w_rd_idx] ? r_bank[w_rd_bank][w_rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (raise_valid) r_bank[r_fill][freq_out] <= raise_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_fill  <= 1'b0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_occ[0] <= '0;
      r_occ[1] <= '0;
      r_valid <= 1'b0;
      r_fin   <= 1'b0;
      r_drop  <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_drop <= 1'b0;
      if (raise_valid) r_occ[r_fill][freq_out] <= 1'b1;
      // Discard clears occupancy after the same-cycle write, so that write is dropped too.
      if (raise_fin) begin
        if (w_free) begin
          r_fill           <= ~r_fill;
          r_occ[~r_fill]   <= '0;
          r_pend           <= 1'b1;
        end else begin
          r_occ[r_fill]    <= '0;
          r_drop           <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_idx   <= '0;
            r_fin   <= (LAST == '0);
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (r_cnt == LAST) begin
              r_pend  <= 1'b0;
              r_valid <= 1'b0;
              r_fin   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_data <= w_word;
              r_idx  <= r_cnt + 1'b1;
              r_fin  <= ((r_cnt + 1'b1) == LAST);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifft_valid = r_valid;
  assign ifft_data  = r_data;
  assign ifft_idx   = r_idx;
  assign ifft_fin   = r_fin;
  assign drop       = r_drop;

`ifdef RAISE_SINK_STAT_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_last_hs && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (raise_fin && !w_free && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
`endif

endmodule
